temp_disp_ctrl: RTL and testbench
=================================

TEMP_DISP_CTRL -- requirements
Module: temp_disp_ctrl

Interface
REQ-001 Parameter SAMPLE_PERIOD, default 10_000_000: clock cycles from the end of one sample transaction to the next request.
REQ-002 Parameter SCAN_DIV, default 100_000: clock cycles per display-digit scan step.
REQ-003 Parameter ACK_TIMEOUT, default 1_000: maximum cycles sample_req waits for sample_ack.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 c_f_sel  in  1  unit select from the user switch, 0=C, 1=F.
REQ-007 sample_req  out  1  request to the sensor reader.
REQ-008 sample_ack  in  1  sensor reader acknowledge; sample_data is valid in the same cycle.
REQ-009 sample_data  in  13  raw two's-complement temperature code.
REQ-010 tc  out  13  registered code driven to the conversion datapath.
REQ-011 c_f  out  1  registered unit select driven to the conversion datapath.
REQ-012 sign, thou, hund, tens, ones  in  1,4,4,4,4  combinational datapath results for tc/c_f.
REQ-013 an  out  5  active-low one-hot digit enable; bit0=ones, bit1=tens, bit2=hund, bit3=thou, bit4=sign.
REQ-014 digit  out  4  code for the enabled position: 0-9 BCD, 4'hA minus, 4'hF blank.
REQ-015 upd  out  1  one-cycle pulse when new display values are latched.
REQ-016 err  out  1  sticky timeout flag.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, SETTLE.
REQ-018 IDLE: the wait counter counts up. At SAMPLE_PERIOD-1 the FSM SHALL go to REQ.
REQ-019 In IDLE, if c_f_sel differs from c_f, the FSM SHALL go to REQ on the next edge (early resample).
REQ-020 REQ: sample_req SHALL be 1 in REQ only, from a registered output.
REQ-021 On the edge where sample_ack=1 in REQ: tc<=sample_data, c_f<=c_f_sel, err<=0, then go to SETTLE.
REQ-022 In REQ, if ACK_TIMEOUT cycles pass without sample_ack: err<=1, tc and c_f keep their values, go to IDLE.
REQ-023 sample_ack in IDLE or SETTLE SHALL be ignored.
REQ-024 SETTLE, for one cycle: latch sign/thou/hund/tens/ones into the display registers, pulse upd the next cycle, go to IDLE.
REQ-025 The wait counter SHALL clear on every entry to IDLE.
REQ-026 Latency: ack sampled at edge N; the display registers update at edge N+1; upd=1 during cycle N+1 to N+2.
REQ-027 Scan counter: position 0..4 SHALL advance every SCAN_DIV cycles and wrap 4->0.
REQ-028 The scan counter SHALL run independently of the FSM.
REQ-029 Leading-zero blanking, applied to the latched values:
- thou is blank if 0.
- hund is blank if thou=0 and hund=0.
- tens is blank if thou=hund=tens=0.
- ones is never blank.
REQ-030 The sign position SHALL show 4'hA if latched sign=1, else 4'hF.
REQ-031 While err=1, every position SHALL show 4'hA.
REQ-032 an and digit SHALL be registered and change on the same edge.

Reset
REQ-033 During rst, outputs SHALL be:
- sample_req=0, tc=0, c_f=0, upd=0, err=0.
- display registers 0 and sign 0.
- scan position 0, an=5'b11110, digit=0.
REQ-034 During rst, the state SHALL be IDLE with the wait counter preloaded to SAMPLE_PERIOD-1, so REQ is entered on the first edge after rst falls.
REQ-035 rst asserted in any state, including mid-handshake, SHALL abort to the REQ-033 values on that edge.

Verification (SAMPLE_PERIOD=20, SCAN_DIV=4, ACK_TIMEOUT=8)
REQ-036 Release rst, ack after 3 cycles with sample_data=13'h0190 -> sample_req high 3 cycles; tc=13'h0190 next edge; upd pulses once one edge later; next sample_req exactly 20 cycles after IDLE entry.
REQ-037 Datapath returns sign=1, thou=0, hund=0, tens=4, ones=5 -> scan sequence ones=5, tens=4, hund=F, thou=F, sign=A; each position held 4 cycles; an rotates 11110,11101,11011,10111,01111, then wraps.
REQ-038 No ack for 8 cycles -> err=1, sample_req drops, all digits A, tc unchanged; next successful ack -> err=0.
REQ-039 Toggle c_f_sel mid-IDLE -> sample_req next edge; c_f follows at the ack edge; display unchanged before upd.
REQ-040 Assert rst during REQ, with ack arriving the same cycle -> no capture, tc=0, sample_req=0; REQ re-entered one edge after release.
REQ-041 Hold sample_ack=1 constantly -> exactly one capture per transaction; no ack is taken in IDLE or SETTLE.

Source files
------------

// File: rtl/temp_disp_ctrl.sv
// temp_disp_ctrl
//   Periodically requests a temperature sample from the sensor reader. It
//   registers the raw code and unit select for the conversion datapath,
//   latches the converted digits one cycle later, and scans them onto a
//   5-position multiplexed display with leading-zero blanking.
//
// Ports
//   clk, rst          : clock (rising edge) and synchronous active-high reset
//   c_f_sel           : unit switch, 0 = Celsius, 1 = Fahrenheit
//   sample_req        : request to the sensor reader (registered)
//   sample_ack        : reader acknowledge, sample_data valid in the same cycle
//   sample_data[12:0] : raw two's-complement temperature code
//   tc[12:0], c_f     : registered code and unit select for the datapath
//   sign, thou, hund,
//   tens, ones        : combinational datapath results for tc/c_f
//   an[4:0]           : active-low digit enable (0=ones .. 3=thou, 4=sign)
//   digit[3:0]        : 0-9 BCD, 4'hA minus, 4'hF blank
//   upd               : one-cycle pulse after new display values are latched
//   err               : sticky acknowledge-timeout flag
module temp_disp_ctrl #(
   parameter int SAMPLE_PERIOD = 10_000_000,
   parameter int SCAN_DIV      = 100_000,
   parameter int ACK_TIMEOUT   = 1_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        c_f_sel,
   output logic        sample_req,
   input  logic        sample_ack,
   input  logic [12:0] sample_data,
   output logic [12:0] tc,
   output logic        c_f,
   input  logic        sign,
   input  logic [3:0]  thou,
   input  logic [3:0]  hund,
   input  logic [3:0]  tens,
   input  logic [3:0]  ones,
   output logic [4:0]  an,
   output logic [3:0]  digit,
   output logic        upd,
   output logic        err
);

   localparam int WAIT_W = $clog2(SAMPLE_PERIOD + 1);
   localparam int TO_W   = $clog2(ACK_TIMEOUT + 1);
   localparam int SCAN_W = $clog2(SCAN_DIV + 1);

   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SAMPLE_PERIOD - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

   localparam logic [3:0] CODE_MINUS = 4'hA;
   localparam logic [3:0] CODE_BLANK = 4'hF;

   typedef enum logic [1:0] {IDLE, REQ, SETTLE} state_t;

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic [TO_W-1:0]   to_cnt;

   logic              disp_sign;
   logic [3:0]        disp_thou;
   logic [3:0]        disp_hund;
   logic [3:0]        disp_tens;
   logic [3:0]        disp_ones;

   logic [SCAN_W-1:0] scan_cnt;
   logic [2:0]        pos;
   logic [2:0]        pos_next;
   logic [3:0]        sel_code;

   // ---------------------------------------------------------------
   // Sample handshake FSM. The wait counter is preloaded in reset so the
   // first request goes out on the first edge after reset is released.
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wait_cnt   <= WAIT_LAST;
         to_cnt     <= '0;
         sample_req <= 1'b0;
         tc         <= '0;
         c_f        <= 1'b0;
         upd        <= 1'b0;
         err        <= 1'b0;
         disp_sign  <= 1'b0;
         disp_thou  <= '0;
         disp_hund  <= '0;
         disp_tens  <= '0;
         disp_ones  <= '0;
      end else begin
         upd <= 1'b0;
         case (state)
            IDLE: begin
               // A changed unit switch forces an early resample.
               if (wait_cnt == WAIT_LAST || c_f_sel != c_f) begin
                  state      <= REQ;
                  sample_req <= 1'b1;
                  to_cnt     <= '0;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            REQ: begin
               // An ack on the last timeout cycle still counts as success.
               if (sample_ack) begin
                  tc         <= sample_data;
                  c_f        <= c_f_sel;
                  err        <= 1'b0;
                  sample_req <= 1'b0;
                  state      <= SETTLE;
               end else if (to_cnt == TO_LAST) begin
                  err        <= 1'b1;
                  sample_req <= 1'b0;
                  wait_cnt   <= '0;
                  state      <= IDLE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            SETTLE: begin
               // tc/c_f have been stable for one cycle; datapath is valid.
               disp_sign <= sign;
               disp_thou <= thou;
               disp_hund <= hund;
               disp_tens <= tens;
               disp_ones <= ones;
               upd       <= 1'b1;
               wait_cnt  <= '0;
               state     <= IDLE;
            end
            default: begin
               sample_req <= 1'b0;
               wait_cnt   <= '0;
               state      <= IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Per-position display code with leading-zero blanking.
   // ---------------------------------------------------------------
   logic       blank_thou;
   logic       blank_hund;
   logic       blank_tens;
   logic [4:0] pos_blank;
   logic [3:0] pos_val  [5];
   logic [3:0] pos_code [5];

   assign blank_thou = (disp_thou == 4'd0);
   assign blank_hund = blank_thou && (disp_hund == 4'd0);
   assign blank_tens = blank_hund && (disp_tens == 4'd0);
   assign pos_blank  = {~disp_sign, blank_thou, blank_hund, blank_tens, 1'b0};

   assign pos_val[0] = disp_ones;
   assign pos_val[1] = disp_tens;
   assign pos_val[2] = disp_hund;
   assign pos_val[3] = disp_thou;
   assign pos_val[4] = CODE_MINUS;

   generate
      for (genvar gi = 0; gi < 5; gi++) begin : g_pos
         assign pos_code[gi] = err ? CODE_MINUS
                             : (pos_blank[gi] ? CODE_BLANK : pos_val[gi]);
      end
   endgenerate

   // ---------------------------------------------------------------
   // Free-running scan; an and digit are both driven from pos_next so
   // they always switch on the same edge.
   // ---------------------------------------------------------------
   always_comb begin
      pos_next = pos;
      if (scan_cnt == SCAN_LAST) begin
         pos_next = (pos == 3'd4) ? 3'd0 : pos + 3'd1;
      end
   end

   always_comb begin
      sel_code = pos_code[0];
      case (pos_next)
         3'd1:    sel_code = pos_code[1];
         3'd2:    sel_code = pos_code[2];
         3'd3:    sel_code = pos_code[3];
         3'd4:    sel_code = pos_code[4];
         default: sel_code = pos_code[0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         pos      <= 3'd0;
         an       <= 5'b11110;
         digit    <= 4'd0;
      end else begin
         scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + 1'b1;
         pos      <= pos_next;
         an       <= ~(5'b00001 << pos_next);
         digit    <= sel_code;
      end
   end

endmodule

// File: tb/tb_temp_disp_ctrl.sv
// Testbench for temp_disp_ctrl: directed sequences, a table of display
// vectors, and a randomized run checked every cycle against a reference
// model described in terms of elapsed cycles since IDLE/REQ entry.
module tb_temp_disp_ctrl;

   localparam int SP = 20;
   localparam int SD = 4;
   localparam int AT = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        c_f_sel = 1'b0;
   logic        sample_ack = 1'b0;
   logic [12:0] sample_data = '0;
   logic        dp_sign = 1'b0;
   logic [3:0]  dp_thou = '0, dp_hund = '0, dp_tens = '0, dp_ones = '0;

   logic        sample_req, c_f, upd, err;
   logic [12:0] tc;
   logic [4:0]  an;
   logic [3:0]  digit;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   temp_disp_ctrl #(.SAMPLE_PERIOD(SP), .SCAN_DIV(SD), .ACK_TIMEOUT(AT)) dut (
      .clk(clk), .rst(rst), .c_f_sel(c_f_sel),
      .sample_req(sample_req), .sample_ack(sample_ack), .sample_data(sample_data),
      .tc(tc), .c_f(c_f),
      .sign(dp_sign), .thou(dp_thou), .hund(dp_hund), .tens(dp_tens), .ones(dp_ones),
      .an(an), .digit(digit), .upd(upd), .err(err)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic        m_req = 0, m_settle = 0, m_cf = 0, m_upd = 0, m_err = 0, m_sign = 0;
   logic [12:0] m_tc = '0;
   logic [3:0]  m_thou = '0, m_hund = '0, m_tens = '0, m_ones = '0;
   logic [4:0]  m_an = 5'b11110;
   logic [3:0]  m_digit = '0;
   int          idle_age = SP - 1;
   int          req_age = 0;
   int          scan_edges = 0;

   function automatic logic [3:0] shown_code(int p);
      if (m_err) return 4'hA;
      case (p)
         0: return m_ones;
         1: return (m_thou == 0 && m_hund == 0 && m_tens == 0) ? 4'hF : m_tens;
         2: return (m_thou == 0 && m_hund == 0) ? 4'hF : m_hund;
         3: return (m_thou == 0) ? 4'hF : m_thou;
         default: return m_sign ? 4'hA : 4'hF;
      endcase
   endfunction

   task automatic model_step();
      int p;
      if (rst) begin
         m_req = 0; m_settle = 0; idle_age = SP - 1; req_age = 0;
         m_tc = '0; m_cf = 0; m_upd = 0; m_err = 0;
         m_sign = 0; m_thou = '0; m_hund = '0; m_tens = '0; m_ones = '0;
         scan_edges = 0; m_an = 5'b11110; m_digit = 4'd0;
      end else begin
         scan_edges++;
         p = (scan_edges / SD) % 5;
         m_an = ~(5'b00001 << p);
         m_digit = shown_code(p);   // uses values held before this edge
         m_upd = 0;
         if (m_settle) begin
            m_sign = dp_sign; m_thou = dp_thou; m_hund = dp_hund;
            m_tens = dp_tens; m_ones = dp_ones;
            m_upd = 1; m_settle = 0; idle_age = 0;
         end else if (m_req) begin
            req_age++;
            if (sample_ack) begin
               m_tc = sample_data; m_cf = c_f_sel; m_err = 0;
               m_req = 0; m_settle = 1;
            end else if (req_age == AT) begin
               m_err = 1; m_req = 0; idle_age = 0;
            end
         end else begin
            idle_age++;
            if (idle_age == SP || c_f_sel != m_cf) begin
               m_req = 1; req_age = 0;
            end
         end
      end
   endtask

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, expv);
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      cyc++;
      chk("model_sample_req", 32'(sample_req), 32'(m_req));
      chk("model_tc", 32'(tc), 32'(m_tc));
      chk("model_c_f", 32'(c_f), 32'(m_cf));
      chk("model_upd", 32'(upd), 32'(m_upd));
      chk("model_err", 32'(err), 32'(m_err));
      chk("model_an", 32'(an), 32'(m_an));
      chk("model_digit", 32'(digit), 32'(m_digit));
   endtask

   task automatic wait_req(int bound);
      int n = 0;
      while (sample_req !== 1'b1 && n < bound) begin
         tick();
         n++;
      end
      chk("wait_req_bound", 32'(sample_req), 32'd1);
   endtask

   function automatic int an_pos(logic [4:0] a);
      case (a)
         5'b11110: return 0;
         5'b11101: return 1;
         5'b11011: return 2;
         5'b10111: return 3;
         5'b01111: return 4;
         default:  return -1;
      endcase
   endfunction

   typedef struct {
      logic       sign;
      logic [3:0] thou, hund, tens, ones;
      logic [19:0] exp;   // nibble p = expected digit at position p
   } disp_vec_t;

   disp_vec_t vecs [7];
   logic [4:0] an_rec [66];
   logic [3:0] dig_rec [66];

   initial begin
      int n, hi, nu, nr, start, p;
      logic [19:0] e;
      logic [4:0] exp_an [5];
      logic [3:0] exp_dig [5];

      vecs[0] = '{1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 20'hFFFF0};
      vecs[1] = '{1'b0, 4'd1, 4'd0, 4'd0, 4'd7, 20'hF1007};
      vecs[2] = '{1'b1, 4'd0, 4'd3, 4'd0, 4'd0, 20'hAF300};
      vecs[3] = '{1'b0, 4'd0, 4'd0, 4'd9, 4'd9, 20'hFFF99};
      vecs[4] = '{1'b1, 4'd9, 4'd9, 4'd9, 4'd9, 20'hA9999};
      vecs[5] = '{1'b0, 4'd0, 4'd0, 4'd0, 4'd8, 20'hFFFF8};
      vecs[6] = '{1'b0, 4'd0, 4'd5, 4'd0, 4'd1, 20'hFF501};
      exp_an[0] = 5'b11110; exp_an[1] = 5'b11101; exp_an[2] = 5'b11011;
      exp_an[3] = 5'b10111; exp_an[4] = 5'b01111;
      exp_dig[0] = 4'h5; exp_dig[1] = 4'h4; exp_dig[2] = 4'hF;
      exp_dig[3] = 4'hF; exp_dig[4] = 4'hA;

      // ---- reset state ----
      repeat (3) tick();
      chk("rst_sample_req", 32'(sample_req), 32'd0);
      chk("rst_tc", 32'(tc), 32'd0);
      chk("rst_an", 32'(an), 32'b11110);
      chk("rst_digit", 32'(digit), 32'd0);
      chk("rst_err_upd", 32'({err, upd}), 32'd0);

      // ---- first transaction: ack after 3 cycles ----
      rst = 0;
      tick();
      chk("first_req_after_rst", 32'(sample_req), 32'd1);
      hi = 1;
      repeat (2) begin tick(); if (sample_req) hi++; end
      sample_ack = 1; sample_data = 13'h0190;
      dp_sign = 1; dp_thou = 0; dp_hund = 0; dp_tens = 4; dp_ones = 5;
      tick();
      chk("req_high_cycles", 32'(hi), 32'd3);
      chk("tc_capture", 32'(tc), 32'h0190);
      chk("req_drop_on_ack", 32'(sample_req), 32'd0);
      sample_ack = 0;
      tick();
      chk("upd_pulse", 32'(upd), 32'd1);
      n = 0;
      while (sample_req !== 1'b1 && n < 100) begin tick(); n++; end
      chk("idle_to_req_cycles", 32'(n), 32'd20);

      // ---- ack held high: one capture per transaction, scan order ----
      sample_ack = 1;
      n = 0;
      do begin sample_data = 13'($urandom_range(0, 8191)); tick(); n++; end
      while (upd !== 1'b1 && n < 10);
      chk("held_ack_first_upd", 32'(upd), 32'd1);
      nu = 0; nr = 0;
      for (int k = 0; k < 66; k++) begin
         sample_data = 13'($urandom_range(0, 8191));
         tick();
         an_rec[k] = an; dig_rec[k] = digit;
         if (upd) nu++;
         if (sample_req) nr++;
      end
      chk("held_ack_upd_count", 32'(nu), 32'd3);
      chk("held_ack_req_count", 32'(nr), 32'd3);
      start = -1;
      for (int k = 1; k < 46; k++) begin
         if (start < 0 && an_rec[k] == 5'b11110 && an_rec[k-1] != 5'b11110) start = k;
      end
      chk("scan_start_found", 32'(start >= 0), 32'd1);
      if (start >= 0) begin
         for (int j = 0; j < 20; j++) begin
            chk("scan_an_seq", 32'(an_rec[start+j]), 32'(exp_an[j/4]));
            chk("scan_digit_seq", 32'(dig_rec[start+j]), 32'(exp_dig[j/4]));
         end
         chk("scan_wrap", 32'(an_rec[start+20]), 32'b11110);
      end

      // ---- timeout ----
      sample_ack = 0;
      wait_req(30);
      hi = 1; n = 0;
      while (sample_req === 1'b1 && n < 20) begin tick(); n++; if (sample_req) hi++; end
      chk("timeout_req_cycles", 32'(hi), 32'd8);
      chk("timeout_err", 32'(err), 32'd1);
      chk("timeout_tc_kept", 32'(tc), 32'(m_tc));
      repeat (18) begin tick(); chk("err_digit_minus", 32'(digit), 32'hA); end
      wait_req(30);
      sample_ack = 1; sample_data = 13'h0ABC;
      tick();
      chk("err_cleared_by_ack", 32'(err), 32'd0);
      chk("tc_after_err", 32'(tc), 32'h0ABC);

      // ---- early resample on unit change ----
      sample_ack = 0;
      tick();
      repeat (5) tick();
      c_f_sel = 1;
      tick();
      chk("early_resample_req", 32'(sample_req), 32'd1);
      dp_sign = 0; dp_thou = 1; dp_hund = 2; dp_tens = 3; dp_ones = 4;
      sample_ack = 1; sample_data = 13'h1234;
      tick();
      chk("c_f_follows_at_ack", 32'(c_f), 32'd1);
      sample_ack = 0;
      tick();
      chk("resample_upd", 32'(upd), 32'd1);

      // ---- reset during REQ with simultaneous ack ----
      wait_req(30);
      rst = 1; sample_ack = 1; sample_data = 13'h1FFF;
      tick();
      chk("rst_abort_tc", 32'(tc), 32'd0);
      chk("rst_abort_req", 32'(sample_req), 32'd0);
      chk("rst_abort_c_f", 32'(c_f), 32'd0);
      rst = 0; sample_ack = 0;
      tick();
      chk("req_after_rst_release", 32'(sample_req), 32'd1);

      // ---- display vector table ----
      for (int i = 0; i < 7; i++) begin
         wait_req(30);
         dp_sign = vecs[i].sign; dp_thou = vecs[i].thou; dp_hund = vecs[i].hund;
         dp_tens = vecs[i].tens; dp_ones = vecs[i].ones;
         sample_ack = 1; sample_data = 13'($urandom_range(0, 8191));
         tick();
         sample_ack = 0;
         tick();
         tick();
         e = vecs[i].exp;
         for (int t = 0; t < 20; t++) begin
            tick();
            p = an_pos(an);
            chk("vec_an_onehot", 32'(p >= 0), 32'd1);
            if (p >= 0) chk("vec_digit", 32'(digit), 32'(e[4*p +: 4]));
         end
      end

      // ---- randomized run against the model ----
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(0, 399) == 0);
         sample_ack = ($urandom_range(0, 3) == 0);
         sample_data = 13'($urandom_range(0, 8191));
         if ($urandom_range(0, 49) == 0) c_f_sel = ~c_f_sel;
         dp_sign = 1'($urandom_range(0, 1));
         dp_thou = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
         dp_hund = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
         dp_tens = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
         dp_ones = 4'($urandom_range(0, 9));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
